// File: rtl/bk_pkg.sv
// Shared definitions for the Brent-Kung adder operand/result stage.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
// Contents: operand width, settle-counter width, FSM state enum and the
// operand interleave helper that builds the adder's INPUTS bus.
package bk_pkg;

  localparam int BK_WIDTH    = 12;
  // Settle counter holds SETTLE_CYCLES-1, so 4 bits covers the 1..15 range.
  localparam int BK_SETTLE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } bk_state_e;

  // The adder expects operand bits paired per position: even bit = a[i],
  // odd bit = b[i].
  function automatic logic [2*BK_WIDTH-1:0] bk_interleave(
    input logic [BK_WIDTH-1:0] a,
    input logic [BK_WIDTH-1:0] b
  );
    logic [2*BK_WIDTH-1:0] bus;
    bus = '0;
    for (int i = 0; i < BK_WIDTH; i++) begin
      bus[2*i]   = a[i];
      bus[2*i+1] = b[i];
    end
    return bus;
  endfunction

endpackage

// File: rtl/bk_adder_io_stage.sv
// Operand feed and result capture around an external combinational Brent-Kung adder.
// Latency: accept at edge E, sum captured at edge E+SETTLE_CYCLES; one result per SETTLE_CYCLES+1 cycles.
// Backpressure: result held in DONE until out_ready; in_ready follows out_ready in DONE, low in SETTLE.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   in_valid/in_ready     operand stream handshake; in_a, in_b operands
//   adder_in              interleaved operand bus to the adder (registered)
//   adder_out             adder sum, bit WIDTH is carry-out
//   out_valid/out_ready   result stream handshake; out_sum registered sum
//   busy                  high while a transaction is in flight (SETTLE or DONE)
//   txn_count             number of delivered results, wraps silently
module bk_adder_io_stage
  import bk_pkg::*;
#(
  parameter int WIDTH         = BK_WIDTH,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic [2*WIDTH-1:0] adder_in,
  input  logic [WIDTH:0]     adder_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     out_sum,
  output logic               busy,
  output logic [CNT_W-1:0]   txn_count
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("bk_adder_io_stage: SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [BK_SETTLE_W-1:0] LP_CNT_INIT = BK_SETTLE_W'(SETTLE_CYCLES - 1);

  bk_state_e               r_state;
  bk_state_e               w_state_nxt;
  logic [BK_SETTLE_W-1:0]  r_cnt;
  logic [2*WIDTH-1:0]      r_adder_in;
  logic [WIDTH:0]          r_sum;
  logic [CNT_W-1:0]        r_txn;

  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_deliver;
  logic                    w_capture;
  logic [2*WIDTH-1:0]      w_il;

  // Use the shared helper at the native width; fall back to an equivalent
  // generic mapping if the stage is built at another width.
  if (WIDTH == BK_WIDTH) begin : g_il_pkg
    assign w_il = bk_interleave(in_a, in_b);
  end else begin : g_il_gen
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign w_il[2*gi]   = in_a[gi];
      assign w_il[2*gi+1] = in_b[gi];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = SETTLE;
      end
      SETTLE: begin
        if (r_cnt == '0) w_state_nxt = DONE;
      end
      DONE: begin
        // A new pair can be taken on the same edge the result leaves.
        w_in_ready = out_ready;
        if (out_ready) w_state_nxt = in_valid ? SETTLE : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept  = in_valid & w_in_ready;
  assign w_deliver = (r_state == DONE) & out_ready;
  assign w_capture = (r_state == SETTLE) & (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_adder_in <= '0;
      r_sum      <= '0;
      r_txn      <= '0;
    end else begin
      r_state <= w_state_nxt;

      // Operand register only moves on an accept, so the adder inputs stay
      // frozen through SETTLE and DONE.
      if (w_accept) begin
        r_adder_in <= w_il;
        r_cnt      <= LP_CNT_INIT;
      end else if ((r_state == SETTLE) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_capture) r_sum <= adder_out;

      if (w_deliver) r_txn <= r_txn + CNT_W'(1);
    end
  end

  assign in_ready  = w_in_ready;
  assign adder_in  = r_adder_in;
  assign out_valid = (r_state == DONE);
  assign out_sum   = r_sum;
  assign busy      = (r_state != IDLE);
  assign txn_count = r_txn;

endmodule
